// File: rtl/day_loader_if.sv
// Load handshake between the day entry loader and the downstream day counter.
interface day_loader_if;
  localparam int unsigned VALUE_W = 7;

  logic               load_valid;
  logic               load_ready;
  logic [VALUE_W-1:0] load_value;

  modport master (output load_valid, output load_value, input load_ready);
  modport slave  (input load_valid, input load_value, output load_ready);
endinterface

// File: rtl/day_loader.sv
// Debounced pushbutton loader: captures a two-digit BCD day from switches on a
// press, validates it, and offers the binary value over a valid/ready handshake.
module day_loader #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input  logic               ADC_CLK_10,
  input  logic               reset,
  input  logic               key_n,
  input  logic [7:0]         sw,
  day_loader_if.master       load,
  output logic               err,
  output logic               busy
);
  localparam int unsigned CNT_W   = 20;
  localparam int unsigned VALUE_W = 7;

  typedef enum logic [1:0] {IDLE, CHECK, OFFER} state_t;

  logic             key_s1, key_s2;
  logic             stable;
  logic             press;
  logic [CNT_W-1:0] db_cnt;

  state_t             state, state_nxt;
  logic [7:0]         entry, entry_nxt;
  logic [VALUE_W-1:0] value_nxt;
  logic               err_nxt;
  logic               entry_ok_c;
  logic [VALUE_W-1:0] day_bin_c;

  // Two-flop synchronizer for the raw button.
  always_ff @(posedge ADC_CLK_10) begin
    if (!reset) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
    end
  end

  // Accept a new level only after it differs from the stable level for
  // DEBOUNCE_CYCLES consecutive cycles; a 1->0 acceptance is the press event.
  always_ff @(posedge ADC_CLK_10) begin
    if (!reset) begin
      stable <= 1'b1;
      db_cnt <= '0;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (key_s2 == stable) begin
        db_cnt <= '0;
      end else if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable <= key_s2;
        db_cnt <= '0;
        press  <= ~key_s2;
      end else begin
        db_cnt <= db_cnt + CNT_W'(1);
      end
    end
  end

  assign entry_ok_c = (entry[7:4] <= 4'd9) && (entry[3:0] <= 4'd9) && (entry != 8'h00);
  assign day_bin_c  = VALUE_W'(entry[7:4]) * VALUE_W'(10) + VALUE_W'(entry[3:0]);

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    entry_nxt = entry;
    value_nxt = load.load_value;
    err_nxt   = err;
    case (state)
      IDLE: begin
        if (press) begin
          entry_nxt = sw;
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (entry_ok_c) begin
          value_nxt = day_bin_c;
          err_nxt   = 1'b0;
          state_nxt = OFFER;
        end else begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      OFFER: begin
        if (load.load_valid && load.load_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs; valid/busy track the next state so they
  // line up with the state register.
  always_ff @(posedge ADC_CLK_10) begin
    if (!reset) begin
      state           <= IDLE;
      entry           <= 8'h00;
      load.load_value <= '0;
      load.load_valid <= 1'b0;
      err             <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state           <= state_nxt;
      entry           <= entry_nxt;
      load.load_value <= value_nxt;
      load.load_valid <= (state_nxt == OFFER);
      err             <= err_nxt;
      busy            <= (state_nxt != IDLE);
    end
  end
endmodule

// File: tb/tb_day_loader.sv
// Self-checking bench for day_loader: directed scenarios plus random stimulus,
// compared every cycle against a behavioural model of the button/handshake.
module tb_day_loader;
  localparam int unsigned N = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key_n = 1'b1;
  logic [7:0] sw = 8'h00;
  logic       err, busy;

  day_loader_if lif();

  day_loader #(.DEBOUNCE_CYCLES(N)) dut (
    .ADC_CLK_10 (clk),
    .reset      (reset),
    .key_n      (key_n),
    .sw         (sw),
    .load       (lif.master),
    .err        (err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs as seen by the DUT at each rising edge.
  logic       s_rst = 1'b0, s_key = 1'b1, s_rdy = 1'b0;
  logic [7:0] s_sw = 8'h00;
  always @(posedge clk) begin
    s_rst <= reset;
    s_key <= key_n;
    s_sw  <= sw;
    s_rdy <= lif.load_ready;
  end

  // Behavioural model: button level reaches the debouncer two edges late; a
  // level is accepted after N consecutive differing samples.
  bit   sync_line[$];
  bit   m_stable = 1'b1;
  int   m_run = 0;
  bit   m_press = 1'b0;
  bit   m_check = 1'b0;
  bit   m_offer = 1'b0;
  bit   m_err = 1'b0;
  int   m_value = 0;
  logic [7:0] m_entry = 8'h00;
  int   exp_q[$];
  int   act_q[$];
  int   valid_cycles = 0;
  int   busy_cycles = 0;

  function automatic int day_of(input logic [7:0] e);
    int t, o;
    t = int'(e) / 16;
    o = int'(e) % 16;
    if (t > 9 || o > 9 || (t == 0 && o == 0)) return -1;
    return t * 10 + o;
  endfunction

  task automatic model_step();
    bit sync_now;
    if (!s_rst) begin
      sync_line = '{1'b1, 1'b1};
      m_stable = 1'b1; m_run = 0; m_press = 1'b0;
      m_check = 1'b0; m_offer = 1'b0; m_err = 1'b0;
      m_value = 0; m_entry = 8'h00;
    end else begin
      if (m_offer) begin
        if (s_rdy) begin
          m_offer = 1'b0;
          exp_q.push_back(m_value);
        end
      end else if (m_check) begin
        m_check = 1'b0;
        if (day_of(m_entry) >= 0) begin
          m_value = day_of(m_entry);
          m_err   = 1'b0;
          m_offer = 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end else if (m_press) begin
        m_entry = s_sw;
        m_check = 1'b1;
      end
      sync_now = sync_line.pop_front();
      sync_line.push_back(s_key);
      m_press = 1'b0;
      if (sync_now != m_stable) begin
        m_run++;
        if (m_run == N) begin
          m_stable = sync_now;
          m_run    = 0;
          m_press  = (sync_now == 1'b0);
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  // Per-cycle compare and transfer monitor, away from the active edge.
  always @(negedge clk) begin
    model_step();
    chk("load_valid", int'(lif.load_valid), int'(m_offer));
    chk("load_value", int'(lif.load_value), m_value);
    chk("err",        int'(err),            int'(m_err));
    chk("busy",       int'(busy),           int'(m_offer | m_check));
    if (lif.load_valid) valid_cycles++;
    if (busy) busy_cycles++;
    if (lif.load_valid && lif.load_ready && reset) act_q.push_back(int'(lif.load_value));
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_release(input logic [7:0] v, input int hold);
    sw = v;
    key_n = 1'b0;
    cyc(hold);
    key_n = 1'b1;
    cyc(12);
  endtask

  int base, vb, bb, seg;

  initial begin
    lif.load_ready = 1'b0;
    cyc(3);
    chk("rst_valid", int'(lif.load_valid), 0);
    chk("rst_value", int'(lif.load_value), 0);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_err",   int'(err), 0);
    reset = 1'b1;
    cyc(2);

    // Clean press of 42 with ready held high.
    lif.load_ready = 1'b1;
    base = act_q.size(); vb = valid_cycles; bb = busy_cycles;
    press_release(8'h42, 12);
    chk("p42_xfers", act_q.size() - base, 1);
    chk("p42_value", act_q[act_q.size()-1], 42);
    chk("p42_err",   int'(err), 0);
    chk("p42_valid_cycles", valid_cycles - vb, 1);
    chk("p42_busy_cycles",  busy_cycles - bb, 2);

    // Bounce every 2 cycles, then settle low.
    base = act_q.size();
    sw = 8'h23;
    for (int i = 0; i < 10; i++) begin
      key_n = ~key_n;
      cyc(2);
    end
    chk("bounce_no_event", act_q.size() - base, 0);
    press_release(8'h23, 14);
    chk("bounce_xfers", act_q.size() - base, 1);

    // Invalid entries, then 99.
    base = act_q.size(); vb = valid_cycles;
    press_release(8'h00, 12);
    chk("e00_err", int'(err), 1);
    press_release(8'h5A, 12);
    chk("e5a_err", int'(err), 1);
    chk("inval_valid_cycles", valid_cycles - vb, 0);
    chk("inval_xfers", act_q.size() - base, 0);
    press_release(8'h99, 12);
    chk("p99_value", act_q[act_q.size()-1], 99);
    chk("p99_err", int'(err), 0);

    // Stalled offer of 7; second press with new switches is lost.
    lif.load_ready = 1'b0;
    base = act_q.size();
    press_release(8'h07, 10);
    chk("stall_valid", int'(lif.load_valid), 1);
    press_release(8'h31, 10);
    chk("stall_value", int'(lif.load_value), 7);
    chk("stall_valid2", int'(lif.load_valid), 1);
    lif.load_ready = 1'b1;
    cyc(3);
    chk("stall_xfer_value", act_q[act_q.size()-1], 7);
    cyc(20);
    chk("stall_xfers", act_q.size() - base, 1);

    // Reset pulse while offering.
    lif.load_ready = 1'b0;
    base = act_q.size();
    press_release(8'h15, 10);
    chk("preoffer_valid", int'(lif.load_valid), 1);
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    chk("rstoffer_valid", int'(lif.load_valid), 0);
    chk("rstoffer_value", int'(lif.load_value), 0);
    chk("rstoffer_busy",  int'(busy), 0);
    lif.load_ready = 1'b1;
    cyc(5);
    chk("rstoffer_xfers", act_q.size() - base, 0);

    // Long hold gives one event; release and press again gives another.
    base = act_q.size();
    sw = 8'h50;
    key_n = 1'b0;
    cyc(50);
    chk("hold_xfers", act_q.size() - base, 1);
    key_n = 1'b1;
    cyc(12);
    press_release(8'h61, 12);
    chk("hold2_xfers", act_q.size() - base, 2);
    chk("hold2_value", act_q[act_q.size()-1], 61);

    // Randomized bouncing key, switches, ready and occasional reset.
    seg = 1;
    for (int i = 0; i < 3000; i++) begin
      seg--;
      if (seg == 0) begin
        key_n = ~key_n;
        seg = int'($urandom_range(1, 12));
      end
      if ($urandom_range(0, 7) == 0)
        sw = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255))
                                         : 8'({4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))});
      lif.load_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 199) != 0);
      cyc(1);
    end
    reset = 1'b1;
    key_n = 1'b1;
    lif.load_ready = 1'b1;
    cyc(30);

    // Scoreboard: every transfer against the model's.
    chk("xfer_total", act_q.size(), exp_q.size());
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
      chk("xfer_value", act_q[i], exp_q[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/day_loader.md
DAY_LOADER -- requirements
Module: day_loader

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 100000 (10 ms at 10 MHz), consecutive cycles a new synchronized key level must persist before it is accepted; legal range 2..2^20-1.
REQ-002 ADC_CLK_10  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on ADC_CLK_10 rising edge.
REQ-004 key_n  input  1  raw asynchronous pushbutton, active-low (0 = pressed), bouncy.
REQ-005 sw  input  8  day entry as two BCD digits: sw[7:4] tens, sw[3:0] ones.
REQ-006 load_ready  input  1  downstream day counter accepts a load this cycle.
REQ-007 load_valid  output  1  load_value holds a validated day awaiting acceptance.
REQ-008 load_value  output  7  binary day value, 1..99.
REQ-009 err  output  1  last press carried an invalid entry; intended for an LED.
REQ-010 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-011 key_n SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Debounce: a counter SHALL increment each cycle the synchronized level differs from the registered stable level, clear to 0 on any cycle they match, and on reaching DEBOUNCE_CYCLES SHALL update the stable level and clear.
REQ-013 A press event SHALL be a single-cycle pulse generated on the stable level's 1->0 transition; release (0->1) generates no event.
REQ-014 FSM states: IDLE, CHECK, OFFER.
REQ-015 IDLE: on press event, SHALL register sw into an entry register and enter CHECK next cycle.
REQ-016 CHECK (exactly one cycle): entry valid iff tens<=9, ones<=9, and entry != 8'h00.
REQ-017 CHECK valid: load_value <= tens*10+ones (7-bit, no overflow possible for valid entries), err <= 0, go to OFFER.
REQ-018 CHECK invalid: err <= 1, load_value unchanged, go to IDLE; err SHALL remain 1 until the next CHECK.
REQ-019 OFFER: load_valid = 1; load_value SHALL be stable; transfer occurs on a cycle with load_valid & load_ready, after which the FSM SHALL return to IDLE and load_valid SHALL be 0 next cycle.
REQ-020 load_ready SHALL be ignored outside OFFER; load_valid SHALL never assert outside OFFER.
REQ-021 Press events in CHECK or OFFER SHALL be discarded, not queued; sw changes after capture SHALL NOT affect load_value.
REQ-022 OFFER SHALL wait indefinitely for load_ready; no timeout.
REQ-023 Latency: if load_ready is held high, load_valid SHALL rise 2 cycles after the press-event cycle and be high for exactly 1 cycle.
REQ-024 Holding key_n low indefinitely SHALL produce exactly one press event; a new event requires debounced release then debounced press.

Reset
REQ-025 While reset=0 at a clock edge: FSM IDLE, synchronizer flops 1, stable level 1, debounce counter 0, entry 0, load_value 0, load_valid 0, err 0, busy 0.
REQ-026 Reset asserted mid-OFFER SHALL drop load_valid the next cycle with no transfer; a key held low through reset release SHALL yield a press event only after DEBOUNCE_CYCLES cycles of the synchronized low level.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 sw=8'h42, clean press, load_ready=1 -> single load_valid pulse, load_value=42, err=0, busy high 2 cycles.
REQ-028 key_n toggles every 2 cycles for 20 cycles then settles low -> exactly one transfer; no event during bounce.
REQ-029 sw=8'h00, then sw=8'h5A, separate presses -> err=1 each time, load_valid never asserts; then sw=8'h99 press -> load_value=99, err=0.
REQ-030 sw=8'h07, load_ready=0 for 10 cycles, second press and sw=8'h31 during wait -> load_valid held, load_value=7 throughout, transfer when load_ready rises, second press lost.
REQ-031 reset=0 for one cycle while in OFFER -> load_valid=0, load_value=0, busy=0 next cycle; no transfer recorded.
REQ-032 key held low 50 cycles -> exactly one event; release, press again -> second event.
